// File: rtl/uart_rx_ctrl.sv
// UART receive control: baud-rate strobe generator plus a 4-entry first-word-fall-through byte FIFO.
// Define UART_RX_TIMEOUT_EN to build the idle-line timeout; otherwise rx_timeout is tied low.
module uart_rx_ctrl #(
  parameter int BPS_DIV      = 5208,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt_start,
  input  logic       rx_done,
  input  logic [7:0] rx_data_byte,
  output logic       bps_clk,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] fifo_count,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       rx_timeout
);

  localparam int CNT_W = (BPS_DIV > 2) ? $clog2(BPS_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BPS_DIV / 2 - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobe is decoded from the counter, so dropping cnt_start zeroes it before the next mid-bit point.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bps_clk = 1'b0;
    case (state_q)
      IDLE: if (cnt_start) state_d = RUN;
      RUN: begin
        bps_clk = (cnt_q == CNT_MID);
        if (!cnt_start) state_d = IDLE;
        else            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       done_q;
  logic       ovf_q, ovf_d;
  logic       push, pop, full, push_acc, ovf_evt;

  always_comb begin
    push     = rx_done & ~done_q;
    full     = (count_q == 3'd4);
    pop      = out_valid & out_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push_acc = push & (~full | pop);
    ovf_evt  = push & full & ~pop;
    wr_ptr_d = wr_ptr_q + {1'b0, push_acc};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q + {2'b00, push_acc} - {2'b00, pop};
    ovf_d    = ovf_evt ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= rx_done;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= rx_data_byte;
  end

  assign out_valid  = (count_q != 3'd0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_BITS * BPS_DIV;
  localparam int IDLE_W = $clog2(TO_CYC + 1);
  localparam logic [IDLE_W-1:0] TO_LIM = IDLE_W'(TO_CYC);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              to_q, to_d;
  logic              idle_clr;

  // The counter saturates at the limit so the pulse fires once per idle stretch.
  always_comb begin
    idle_clr = cnt_start | (count_q == 3'd0);
    idle_d   = idle_q;
    to_d     = 1'b0;
    if (idle_clr) begin
      idle_d = '0;
    end else if (idle_q != TO_LIM) begin
      idle_d = idle_q + 1'b1;
      to_d   = (idle_q == TO_LIM - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end

  assign rx_timeout = to_q;
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based reference model compared every cycle plus directed literal checks.
// Honours UART_RX_TIMEOUT_EN when expecting rx_timeout.
module tb_uart_rx_ctrl;
  localparam int DIV    = 16;
  localparam int TOB    = 20;
  localparam int TO_CYC = DIV * TOB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cnt_start = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data_byte = 8'h00;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       bps_clk;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       rx_timeout;

  uart_rx_ctrl #(.BPS_DIV(DIV), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_start(cnt_start), .rx_done(rx_done),
    .rx_data_byte(rx_data_byte), .bps_clk(bps_clk), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
    .overflow(overflow), .ovf_clr(ovf_clr), .rx_timeout(rx_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: consecutive high cnt_start edges, byte queue, sticky flag, idle-cycle run length.
  int         m_h = 0;
  logic [7:0] m_q[$];
  logic       m_prev = 1'b0;
  logic       m_ovf = 1'b0;
  int         m_idle = 0;
  int         m_sz;
  bit         m_push, m_pop;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_h = 0; m_q.delete(); m_prev = 1'b0; m_ovf = 1'b0; m_idle = 0;
      end else begin
        m_sz   = m_q.size();
        m_push = rx_done && !m_prev;
        m_pop  = (m_sz != 0) && out_ready;
        if (cnt_start || m_sz == 0) m_idle = 0;
        else m_idle++;
        if (m_pop) void'(m_q.pop_front());
        if (m_push && (m_sz < 4 || m_pop)) m_q.push_back(rx_data_byte);
        if (m_push && m_sz == 4 && !m_pop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_prev = rx_done;
        m_h = cnt_start ? m_h + 1 : 0;
      end
    end
  end

  function automatic logic exp_bps();
    return (m_h >= 1) && (((m_h - 1) % DIV) == (DIV / 2 - 1));
  endfunction

  function automatic logic exp_to();
`ifdef UART_RX_TIMEOUT_EN
    return (m_idle == TO_CYC);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("cyc_bps_clk", bps_clk, exp_bps());
      check("cyc_fifo_count", fifo_count, m_q.size());
      check("cyc_out_valid", out_valid, m_q.size() != 0);
      check("cyc_out_data", out_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
      check("cyc_overflow", overflow, m_ovf);
      check("cyc_rx_timeout", rx_timeout, exp_to());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data_byte = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic drain_expect(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] exp_b [4];
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_byte", out_data, exp_b[i]);
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", fifo_count, 0);
  endtask

  int pulses, first_at, last_at, exp_pulses;

  initial begin
    rst_n = 1'b0;
    tick();
    started = 1'b1;
    tick(); tick();
    check("rst_bps_clk", bps_clk, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rx_timeout", rx_timeout, 0);
    rst_n = 1'b1;
    tick();

    // Baud strobe: 40 cycles of cnt_start gives pulses at counter 7, 16 apart.
    cnt_start = 1'b1;
    pulses = 0; first_at = -1; last_at = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bps_clk) begin
        pulses++;
        if (first_at < 0) first_at = i;
        last_at = i;
      end
    end
    cnt_start = 1'b0;
    check("baud_pulses", pulses, 3);
    check("baud_first", first_at, 7);
    check("baud_spacing", last_at - first_at, 32);

    // Abort mid-bit before the strobe point.
    cnt_start = 1'b1;
    repeat (5) tick();
    cnt_start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bps_clk) pulses++;
    end
    check("abort_no_pulse", pulses, 0);

    // Long rx_done pulse pushes once.
    rx_data_byte = 8'hA5;
    rx_done = 1'b1;
    repeat (5) tick();
    rx_done = 1'b0;
    tick();
    check("one_push_count", fifo_count, 1);
    check("one_push_valid", out_valid, 1);
    check("one_push_data", out_data, 8'hA5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("one_push_drained", out_data, 8'h00);

    // Overflow on fifth byte, FIFO keeps first four.
    for (int b = 1; b <= 5; b++) push_byte(8'(b));
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    drain_expect(8'h01, 8'h02, 8'h03, 8'h04);
    check("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full FIFO: push with simultaneous pop is accepted.
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    rx_data_byte = 8'h77;
    rx_done = 1'b1;
    out_ready = 1'b1;
    tick();
    rx_done = 1'b0;
    out_ready = 1'b0;
    check("full_pp_count", fifo_count, 4);
    check("full_pp_ovf", overflow, 0);
    tick();
    drain_expect(8'h22, 8'h33, 8'h44, 8'h77);

    // Set wins over clear in the same cycle.
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
    rx_data_byte = 8'hA5;
    rx_done = 1'b1;
    ovf_clr = 1'b1;
    tick();
    rx_done = 1'b0;
    ovf_clr = 1'b0;
    check("setwins_ovf", overflow, 1);
    check("setwins_count", fifo_count, 4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    drain_expect(8'hA1, 8'hA2, 8'hA3, 8'hA4);

    // Empty FIFO with out_ready high: push only.
    out_ready = 1'b1;
    rx_data_byte = 8'h3C;
    rx_done = 1'b1;
    tick();
    check("empty_pp_count", fifo_count, 1);
    check("empty_pp_data", out_data, 8'h3C);
    rx_done = 1'b0;
    tick();
    out_ready = 1'b0;
    check("empty_pp_drained", fifo_count, 0);

    // Partially filled: push and pop together keep the count.
    push_byte(8'h5A); push_byte(8'h6B);
    rx_data_byte = 8'h7C;
    rx_done = 1'b1;
    out_ready = 1'b1;
    tick();
    rx_done = 1'b0;
    out_ready = 1'b0;
    check("mid_pp_count", fifo_count, 2);
    check("mid_pp_head", out_data, 8'h6B);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;

    // Idle timeout with one byte queued, then none when empty.
`ifdef UART_RX_TIMEOUT_EN
    exp_pulses = 1;
`else
    exp_pulses = 0;
`endif
    push_byte(8'hE1);
    pulses = 0;
    for (int i = 0; i < TO_CYC + 20; i++) begin
      if (rx_timeout) pulses++;
      tick();
    end
    check("timeout_pulses", pulses, exp_pulses);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < TO_CYC + 20; i++) begin
      tick();
      if (rx_timeout) pulses++;
    end
    check("timeout_empty", pulses, 0);

    // cnt_start activity restarts the idle count.
    push_byte(8'hE2);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rx_timeout) pulses++;
    end
    cnt_start = 1'b1;
    tick();
    cnt_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rx_timeout) pulses++;
    end
    check("timeout_restart", pulses, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset during RUN with three bytes queued.
    cnt_start = 1'b1;
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
    repeat (3) tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_bps_clk", bps_clk, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 8'h00);
    check("arst_fifo_count", fifo_count, 0);
    check("arst_overflow", overflow, 0);
    check("arst_rx_timeout", rx_timeout, 0);
    cnt_start = 1'b0;
    #10 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bps_clk || rx_timeout) pulses++;
    end
    check("arst_no_pulse", pulses, 0);
    check("arst_count_after", fifo_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
